// File: rtl/pkt_rr_scheduler8_pkg.sv
// Shared constants and types for the 8-port
// round-robin packet scheduler.
package pkt_rr_scheduler8_pkg;

    localparam int NPORT = 8;
    localparam int IDXW  = 3;
    localparam int CNTW  = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/pkt_rr_scheduler8_rr_pick8.sv
// Rotating-priority picker: first eligible port
// at or after the pointer, wrapping 7 -> 0.
module rr_pick8
    import pkt_rr_scheduler8_pkg::*;
(
    input  logic [NPORT-1:0] eligible,
    input  logic [IDXW-1:0]  pointer,
    output logic [NPORT-1:0] winner,
    output logic [IDXW-1:0]  index,
    output logic             any
);

    logic            found;
    logic [IDXW-1:0] probe;

    // scan pointer, pointer+1, ... and keep the first hit
    always_comb begin
        found  = 1'b0;
        probe  = '0;
        index  = '0;
        winner = '0;
        any    = |eligible;
        for (int i = 0; i < NPORT; i++) begin
            probe = pointer + IDXW'(i);
            if (!found && eligible[probe]) begin
                found = 1'b1;
                index = probe;
            end
        end
        if (any) winner[index] = 1'b1;
    end

endmodule

// File: rtl/pkt_rr_scheduler8.sv
// Packet-granular round-robin scheduler with
// per-packet grant hold and beat timeout.
module pkt_rr_scheduler8
    import pkt_rr_scheduler8_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             qArbitEnable,
    input  logic [NPORT-1:0] qvRequest,
    input  logic [NPORT-1:0] qvMask,
    input  logic             qBeatValid,
    input  logic             qBeatEop,
    output logic [NPORT-1:0] qvGrant,
    output logic [IDXW-1:0]  qvGrantIndex,
    output logic             qGrantValid,
    output logic             qTimeoutErr
);

    localparam logic [CNTW-1:0] TMO_LAST =
        CNTW'(TIMEOUT_CYCLES - 1);

    sched_state_t    state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [NPORT-1:0] grant_d;
    logic [IDXW-1:0] idx_d;
    logic            gvld_d;
    logic            terr_d;

    logic [NPORT-1:0] eligible;
    logic [NPORT-1:0] pick_win;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_any;

    assign eligible = qvRequest & ~qvMask;

    rr_pick8 u_pick (
        .eligible (eligible),
        .pointer  (ptr_q),
        .winner   (pick_win),
        .index    (pick_idx),
        .any      (pick_any)
    );

    // state, pointer, counter and registered outputs
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            qvGrant      <= '0;
            qvGrantIndex <= '0;
            qGrantValid  <= 1'b0;
            qTimeoutErr  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            qvGrant      <= grant_d;
            qvGrantIndex <= idx_d;
            qGrantValid  <= gvld_d;
            qTimeoutErr  <= terr_d;
        end
    end

    // next state: arbitrate, hold for packet, release
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = qvGrant;
        idx_d   = qvGrantIndex;
        gvld_d  = qGrantValid;
        terr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (qArbitEnable && pick_any) begin
                    grant_d = pick_win;
                    idx_d   = pick_idx;
                    gvld_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (qBeatValid && qBeatEop) begin
                    grant_d = '0;
                    gvld_d  = 1'b0;
                    ptr_d   = qvGrantIndex + IDXW'(1);
                    state_d = S_GAP;
                end else if (qBeatValid) begin
                    cnt_d = '0;
                end else if (cnt_q == TMO_LAST) begin
                    grant_d = '0;
                    gvld_d  = 1'b0;
                    terr_d  = 1'b1;
                    ptr_d   = qvGrantIndex + IDXW'(1);
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
